// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// State encoding plus the CRC-8 polynomial, seed and single-bit update.
package config_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_WAIT_WORD,
      ST_SHIFT,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

   // One MSB-first, non-reflected CRC-8 step for a single serial bit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic [7:0] shifted;
      shifted = {crc[6:0], 1'b0};
      return (crc[7] ^ bit_in) ? (shifted ^ CRC8_POLY) : shifted;
   endfunction

endpackage

// File: rtl/config_crc8.sv
// Serial CRC-8 over the bits pushed into the config chain.
// Used by config_loader only when CONFIG_LOADER_CRC_EN is defined.
module config_crc8
   import config_loader_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic [7:0] crc
);

   logic [7:0] crc_reg;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         crc_reg <= CRC8_INIT;
      end else if (bit_valid) begin
         crc_reg <= crc8_step(crc_reg, bit_in);
      end
   end

   assign crc = crc_reg;

endmodule

// File: rtl/config_loader.sv
// Bitstream loader: accepts words over valid/ready and serialises them MSB-first into the
// tile config chain, then releases the fabric. CONFIG_LOADER_CRC_EN adds a trailing CRC-8 check.
module config_loader
   import config_loader_pkg::*;
#(
   parameter int CHAIN_LENGTH = 24,
   parameter int WORD_WIDTH   = 8,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  config_out,
   output logic                  config_enable,
   output logic                  config_nreset,
   output logic                  fabric_nreset,
   output logic                  fabric_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
   localparam int WB_W  = $clog2(WORD_WIDTH + 1);
   localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

`ifdef CONFIG_LOADER_CRC_EN
   localparam state_t END_STATE = ST_CHECK;
`else
   localparam state_t END_STATE = ST_DONE;
`endif

   state_t                state_reg, state_next;
   logic [CNT_W-1:0]      bits_left_reg, bits_left_next;
   logic [WB_W-1:0]       word_bits_reg, word_bits_next;
   logic [WORD_WIDTH-1:0] shreg_reg, shreg_next;
   logic [CLR_W-1:0]      clear_cnt_reg, clear_cnt_next;

   logic config_out_reg, config_out_next;
   logic config_enable_reg, config_enable_next;
   logic config_nreset_reg, config_nreset_next;
   logic fabric_nreset_reg, fabric_nreset_next;
   logic fabric_enable_reg, fabric_enable_next;
   logic word_ready_reg, word_ready_next;
   logic busy_reg, busy_next;
   logic done_reg, done_next;
   logic error_reg, error_next;

   logic transfer;
   assign transfer = word_valid && word_ready_reg;

`ifdef CONFIG_LOADER_CRC_EN
   logic [7:0] crc_value;

   // CRC follows the bits on the same edge they are presented to the chain.
   config_crc8 u_crc (
      .clock     (clock),
      .reset     (reset),
      .clear     (state_reg == ST_CLEAR),
      .bit_valid (config_enable_next),
      .bit_in    (config_out_next),
      .crc       (crc_value)
   );
`endif

   always_comb begin
      state_next         = state_reg;
      bits_left_next     = bits_left_reg;
      word_bits_next     = word_bits_reg;
      shreg_next         = shreg_reg;
      clear_cnt_next     = clear_cnt_reg;
      config_out_next    = config_out_reg;
      config_enable_next = 1'b0;
      error_next         = error_reg;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next     = ST_CLEAR;
               clear_cnt_next = CLR_W'(CLEAR_CYCLES - 1);
               bits_left_next = CNT_W'(CHAIN_LENGTH);
               error_next     = 1'b0;
            end
         end
         ST_CLEAR: begin
            if (clear_cnt_reg == '0) begin
               state_next = ST_WAIT_WORD;
            end else begin
               clear_cnt_next = clear_cnt_reg - CLR_W'(1);
            end
         end
         ST_WAIT_WORD: begin
            if (transfer) begin
               // First bit goes out on the accept edge; word_bits counts the ones still to follow.
               state_next         = ST_SHIFT;
               config_out_next    = word_in[WORD_WIDTH-1];
               config_enable_next = 1'b1;
               shreg_next         = {word_in[WORD_WIDTH-2:0], 1'b0};
               bits_left_next     = bits_left_reg - CNT_W'(1);
               word_bits_next     = (int'(bits_left_reg) >= WORD_WIDTH) ?
                                    WB_W'(WORD_WIDTH - 1) : WB_W'(int'(bits_left_reg) - 1);
            end
         end
         ST_SHIFT: begin
            if (word_bits_reg == '0) begin
               state_next = (bits_left_reg == '0) ? END_STATE : ST_WAIT_WORD;
            end else begin
               config_out_next    = shreg_reg[WORD_WIDTH-1];
               config_enable_next = 1'b1;
               shreg_next         = {shreg_reg[WORD_WIDTH-2:0], 1'b0};
               bits_left_next     = bits_left_reg - CNT_W'(1);
               word_bits_next     = word_bits_reg - WB_W'(1);
            end
         end
`ifdef CONFIG_LOADER_CRC_EN
         ST_CHECK: begin
            if (transfer) begin
               state_next = ST_DONE;
               error_next = (word_in[7:0] != crc_value);
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered without extra lag.
      config_nreset_next = (state_next != ST_CLEAR);
      word_ready_next    = (state_next == ST_WAIT_WORD) || (state_next == ST_CHECK);
      busy_next          = (state_next != ST_IDLE) && (state_next != ST_DONE);
      done_next          = (state_next == ST_DONE);
      fabric_nreset_next = done_next && !error_next;
      fabric_enable_next = done_next && !error_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= ST_IDLE;
         bits_left_reg     <= '0;
         word_bits_reg     <= '0;
         shreg_reg         <= '0;
         clear_cnt_reg     <= '0;
         config_out_reg    <= 1'b0;
         config_enable_reg <= 1'b0;
         config_nreset_reg <= 1'b1;
         fabric_nreset_reg <= 1'b0;
         fabric_enable_reg <= 1'b0;
         word_ready_reg    <= 1'b0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
         error_reg         <= 1'b0;
      end else begin
         state_reg         <= state_next;
         bits_left_reg     <= bits_left_next;
         word_bits_reg     <= word_bits_next;
         shreg_reg         <= shreg_next;
         clear_cnt_reg     <= clear_cnt_next;
         config_out_reg    <= config_out_next;
         config_enable_reg <= config_enable_next;
         config_nreset_reg <= config_nreset_next;
         fabric_nreset_reg <= fabric_nreset_next;
         fabric_enable_reg <= fabric_enable_next;
         word_ready_reg    <= word_ready_next;
         busy_reg          <= busy_next;
         done_reg          <= done_next;
         error_reg         <= error_next;
      end
   end

   assign word_ready    = word_ready_reg;
   assign config_out    = config_out_reg;
   assign config_enable = config_enable_reg;
   assign config_nreset = config_nreset_reg;
   assign fabric_nreset = fabric_nreset_reg;
   assign fabric_enable = fabric_enable_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign error         = error_reg;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: a 24-bit and a 20-bit chain instance, a tile-chain model per instance
// and a bit scoreboard filled on word accept. CRC scenarios run when CONFIG_LOADER_CRC_EN is defined.
module tb_config_loader;

   logic       clk;
   logic       reset;
   logic       start;
   logic       word_valid;
   logic [7:0] word_in;
   logic       sel;

   logic start24, valid24, start20, valid20;
   logic wr24, co24, ce24, cn24, fn24, fe24, busy24, done24, err24;
   logic wr20, co20, ce20, cn20, fn20, fe20, busy20, done20, err20;

   assign start24 = start & ~sel;
   assign valid24 = word_valid & ~sel;
   assign start20 = start & sel;
   assign valid20 = word_valid & sel;

   config_loader #(.CHAIN_LENGTH(24), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dut24 (
      .clock(clk), .reset(reset), .start(start24), .word_in(word_in), .word_valid(valid24),
      .word_ready(wr24), .config_out(co24), .config_enable(ce24), .config_nreset(cn24),
      .fabric_nreset(fn24), .fabric_enable(fe24), .busy(busy24), .done(done24), .error(err24));

   config_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dut20 (
      .clock(clk), .reset(reset), .start(start20), .word_in(word_in), .word_valid(valid20),
      .word_ready(wr20), .config_out(co20), .config_enable(ce20), .config_nreset(cn20),
      .fabric_nreset(fn20), .fabric_enable(fe20), .busy(busy20), .done(done20), .error(err20));

   logic o_ready, o_en, o_nreset, o_fn, o_fe, o_busy, o_done, o_err;
   assign o_ready  = sel ? wr20   : wr24;
   assign o_en     = sel ? ce20   : ce24;
   assign o_nreset = sel ? cn20   : cn24;
   assign o_fn     = sel ? fn20   : fn24;
   assign o_fe     = sel ? fe20   : fe24;
   assign o_busy   = sel ? busy20 : busy24;
   assign o_done   = sel ? done20 : done24;
   assign o_err    = sel ? err20  : err24;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tile chain models: cleared by config_nreset, shift on config_enable.
   logic [23:0] chain24;
   logic [19:0] chain20;
   always @(posedge clk) begin
      if (!cn24) chain24 <= '0;
      else if (ce24) chain24 <= {chain24[22:0], co24};
      if (!cn20) chain20 <= '0;
      else if (ce20) chain20 <= {chain20[18:0], co20};
   end

   logic q24[$];
   logic q20[$];
   always @(negedge clk) begin
      if (ce24) q24.push_back(co24);
      if (ce20) q20.push_back(co20);
   end

   int         n_checks = 0;
   int         n_fail   = 0;
   logic       exp_q[$];
   int         rem_bits;
   int         load_base;
   logic [7:0] crc_model;

   function automatic int obs_count();
      return sel ? q20.size() : q24.size();
   endfunction

   function automatic logic obs_bit(input int idx);
      return sel ? q20[idx] : q24[idx];
   endfunction

   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
      logic [7:0] r;
      r = {c[6:0], 1'b0};
      if (c[7] ^ b) r = r ^ 8'h07;
      return r;
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic begin_load(input int len);
      rem_bits  = len;
      crc_model = 8'h00;
      exp_q.delete();
      load_base = obs_count();
      pulse_start();
   endtask

   task automatic send_word(input logic [7:0] w, input bit data);
      int t;
      @(negedge clk);
      word_in    = w;
      word_valid = 1'b1;
      t = 0;
      while (!o_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!o_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_word_timeout word=0x%02h actual_ready=%b required_ready=1", w, o_ready);
      end else if (data) begin
         for (int i = 7; i >= 0; i--) begin
            if (rem_bits > 0) begin
               exp_q.push_back(w[i]);
               crc_model = crc_step(crc_model, w[i]);
               rem_bits--;
            end
         end
      end
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      $display("word 0x%02h accepted by dut%0d at %0t", w, sel ? 20 : 24, $time);
   endtask

   task automatic finish_load();
      int t;
`ifdef CONFIG_LOADER_CRC_EN
      send_word(crc_model, 1'b0);
`endif
      t = 0;
      while (!o_done && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!o_done) begin
         n_checks++; n_fail++;
         $display("FAIL wait_done_timeout actual_done=%b required_done=1", o_done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks += 11;
      if ({co24, ce24, cn24, fn24, fe24, wr24, busy24, done24, err24} !== 9'b001000000) n_fail++;
      if ({co24, ce24, cn24, fn24, fe24, wr24, busy24, done24, err24} !== 9'b001000000)
         $display("FAIL reset_outputs24 actual=%b required=001000000",
                  {co24, ce24, cn24, fn24, fe24, wr24, busy24, done24, err24});
      if (cn24 !== 1'b1) begin n_fail++; $display("FAIL reset_config_nreset actual=%b required=1", cn24); end
      if (ce24 !== 1'b0) begin n_fail++; $display("FAIL reset_config_enable actual=%b required=0", ce24); end
      if (fn24 !== 1'b0) begin n_fail++; $display("FAIL reset_fabric_nreset actual=%b required=0", fn24); end
      if (fe24 !== 1'b0) begin n_fail++; $display("FAIL reset_fabric_enable actual=%b required=0", fe24); end
      if (wr24 !== 1'b0) begin n_fail++; $display("FAIL reset_word_ready actual=%b required=0", wr24); end
      if (busy24 !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy24); end
      if (done24 !== 1'b0) begin n_fail++; $display("FAIL reset_done actual=%b required=0", done24); end
      if (err24 !== 1'b0) begin n_fail++; $display("FAIL reset_error actual=%b required=0", err24); end
      if (co24 !== 1'b0) begin n_fail++; $display("FAIL reset_config_out actual=%b required=0", co24); end
      if ({cn20, busy20, done20} !== 3'b100) begin
         n_fail++; $display("FAIL reset_dut20 actual=%b required=100", {cn20, busy20, done20});
      end
   endtask

   task automatic test_full_words();
      logic b;
      sel = 1'b0;
      begin_load(24);
      n_checks += 3;
      if (o_nreset !== 1'b0) begin n_fail++; $display("FAIL full_clear_nreset actual=%b required=0", o_nreset); end
      if (o_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy actual=%b required=1", o_busy); end
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_c0 actual=%b required=0", o_ready); end
      @(negedge clk);
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_c1 actual=%b required=0", o_ready); end
      @(negedge clk);
      n_checks += 2;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_c2 actual=%b required=1", o_ready); end
      if (o_nreset !== 1'b1) begin n_fail++; $display("FAIL full_nreset_c2 actual=%b required=1", o_nreset); end
      send_word(8'hA5, 1'b1);
      send_word(8'h3C, 1'b1);
      send_word(8'h0F, 1'b1);
      finish_load();
      n_checks += 6;
      if (obs_count() - load_base !== 24) begin
         n_fail++; $display("FAIL full_enable_cycles actual=%0d required=24", obs_count() - load_base);
      end
      if (chain24 !== 24'hA53C0F) begin n_fail++; $display("FAIL full_chain actual=%h required=a53c0f", chain24); end
      if (o_done !== 1'b1) begin n_fail++; $display("FAIL full_done actual=%b required=1", o_done); end
      if (o_fe !== 1'b1) begin n_fail++; $display("FAIL full_fabric_enable actual=%b required=1", o_fe); end
      if (o_fn !== 1'b1) begin n_fail++; $display("FAIL full_fabric_nreset actual=%b required=1", o_fn); end
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL full_error actual=%b required=0", o_err); end
      for (int i = load_base; i < obs_count() && exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_checks++;
         if (obs_bit(i) !== b) begin
            n_fail++; $display("FAIL full_bit%0d actual=%b required=%b", i - load_base, obs_bit(i), b);
         end
      end
   endtask

   task automatic test_stall();
      logic       b;
      logic [7:0] words [2];
      int         t;
      words[0] = 8'h3C;
      words[1] = 8'h0F;
      sel = 1'b0;
      begin_load(24);
      send_word(8'hA5, 1'b1);
      for (int k = 0; k < 2; k++) begin
         t = 0;
         while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            n_checks += 2;
            if (o_en !== 1'b0) begin n_fail++; $display("FAIL stall_enable gap%0d actual=%b required=0", g, o_en); end
            if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready gap%0d actual=%b required=1", g, o_ready); end
         end
         send_word(words[k], 1'b1);
      end
      finish_load();
      n_checks += 2;
      if (obs_count() - load_base !== 24) begin
         n_fail++; $display("FAIL stall_enable_cycles actual=%0d required=24", obs_count() - load_base);
      end
      if (chain24 !== 24'hA53C0F) begin n_fail++; $display("FAIL stall_chain actual=%h required=a53c0f", chain24); end
      for (int i = load_base; i < obs_count() && exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_checks++;
         if (obs_bit(i) !== b) begin
            n_fail++; $display("FAIL stall_bit%0d actual=%b required=%b", i - load_base, obs_bit(i), b);
         end
      end
   endtask

   task automatic test_partial_word();
      logic b;
      sel = 1'b1;
      begin_load(20);
      send_word(8'hA5, 1'b1);
      send_word(8'h3C, 1'b1);
      send_word(8'hF0, 1'b1);
      finish_load();
      n_checks += 3;
      if (obs_count() - load_base !== 20) begin
         n_fail++; $display("FAIL partial_enable_cycles actual=%0d required=20", obs_count() - load_base);
      end
      if (chain20 !== 20'hA53CF) begin n_fail++; $display("FAIL partial_chain actual=%h required=a53cf", chain20); end
      if (o_fe !== 1'b1) begin n_fail++; $display("FAIL partial_fabric_enable actual=%b required=1", o_fe); end
      for (int i = load_base; i < obs_count() && exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_checks++;
         if (obs_bit(i) !== b) begin
            n_fail++; $display("FAIL partial_bit%0d actual=%b required=%b", i - load_base, obs_bit(i), b);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_midload();
      logic b;
      sel = 1'b0;
      begin_load(24);
      send_word(8'hA5, 1'b1);
      send_word(8'h3C, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks += 5;
      if (obs_count() - load_base !== 10) begin
         n_fail++; $display("FAIL midreset_bits_before actual=%0d required=10", obs_count() - load_base);
      end
      if (o_en !== 1'b0) begin n_fail++; $display("FAIL midreset_enable actual=%b required=0", o_en); end
      if (o_fn !== 1'b0) begin n_fail++; $display("FAIL midreset_fabric_nreset actual=%b required=0", o_fn); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy actual=%b required=0", o_busy); end
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready actual=%b required=0", o_ready); end
      begin_load(24);
      send_word(8'hA5, 1'b1);
      pulse_start();
      n_checks += 2;
      if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midstart_busy actual=%b required=1", o_busy); end
      if (o_nreset !== 1'b1) begin n_fail++; $display("FAIL midstart_nreset actual=%b required=1", o_nreset); end
      send_word(8'h3C, 1'b1);
      send_word(8'h0F, 1'b1);
      finish_load();
      n_checks += 3;
      if (obs_count() - load_base !== 24) begin
         n_fail++; $display("FAIL reload_enable_cycles actual=%0d required=24", obs_count() - load_base);
      end
      if (chain24 !== 24'hA53C0F) begin n_fail++; $display("FAIL reload_chain actual=%h required=a53c0f", chain24); end
      if (o_fe !== 1'b1) begin n_fail++; $display("FAIL reload_fabric_enable actual=%b required=1", o_fe); end
      for (int i = load_base; i < obs_count() && exp_q.size() > 0; i++) begin
         b = exp_q.pop_front();
         n_checks++;
         if (obs_bit(i) !== b) begin
            n_fail++; $display("FAIL reload_bit%0d actual=%b required=%b", i - load_base, obs_bit(i), b);
         end
      end
   endtask

`ifdef CONFIG_LOADER_CRC_EN
   task automatic test_crc_good();
      int t;
      sel = 1'b0;
      begin_load(24);
      send_word(8'hA5, 1'b1);
      send_word(8'h3C, 1'b1);
      send_word(8'h0F, 1'b1);
      send_word(8'hA0, 1'b0);
      t = 0;
      while (!o_done && t < 50) begin @(negedge clk); t++; end
      n_checks += 4;
      if (o_done !== 1'b1) begin n_fail++; $display("FAIL crc_good_done actual=%b required=1", o_done); end
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL crc_good_error actual=%b required=0", o_err); end
      if (o_fe !== 1'b1) begin n_fail++; $display("FAIL crc_good_fabric_enable actual=%b required=1", o_fe); end
      if (chain24 !== 24'hA53C0F) begin n_fail++; $display("FAIL crc_good_chain actual=%h required=a53c0f", chain24); end
      exp_q.delete();
   endtask

   task automatic test_crc_bad();
      int t;
      sel = 1'b0;
      begin_load(24);
      send_word(8'hA5, 1'b1);
      send_word(8'h3C, 1'b1);
      send_word(8'h0F, 1'b1);
      send_word(8'hA1, 1'b0);
      t = 0;
      while (!o_done && t < 50) begin @(negedge clk); t++; end
      n_checks += 4;
      if (o_done !== 1'b1) begin n_fail++; $display("FAIL crc_bad_done actual=%b required=1", o_done); end
      if (o_err !== 1'b1) begin n_fail++; $display("FAIL crc_bad_error actual=%b required=1", o_err); end
      if (o_fe !== 1'b0) begin n_fail++; $display("FAIL crc_bad_fabric_enable actual=%b required=0", o_fe); end
      if (o_fn !== 1'b0) begin n_fail++; $display("FAIL crc_bad_fabric_nreset actual=%b required=0", o_fn); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (o_err !== 1'b1) begin n_fail++; $display("FAIL crc_bad_sticky actual=%b required=1", o_err); end
      pulse_start();
      n_checks++;
      if (o_err !== 1'b0) begin n_fail++; $display("FAIL crc_bad_clear_on_start actual=%b required=0", o_err); end
      exp_q.delete();
   endtask
`endif

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      word_valid = 1'b0;
      word_in    = 8'h00;
      sel        = 1'b0;
      test_reset();
      test_full_words();
      test_stall();
      test_partial_word();
      test_reset_midload();
`ifdef CONFIG_LOADER_CRC_EN
      test_crc_good();
      test_crc_bad();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
